// File: rtl/crash_sound_latch.sv
`timescale 1ns/1ps
// crash_sound_latch
//   CPU-side writer for the crash/bang audio path. Captures CPU sound-register
//   writes, derives the 48 kHz sample enable from the system clock, and presents
//   the crash level to the bang generator. The level only changes on sample
//   boundaries, so the consumer never sees a change in the middle of a sample.
//
// Ports
//   clk           in   1  system clock, all logic on posedge
//   reset_n       in   1  asynchronous active-low reset
//   cpu_wr        in   1  one-cycle write strobe from the address decoder
//   cpu_data      in   8  [3:0] crash level, [4] mute, [7:5] ignored
//   clk_en_48KHz  out  1  one-cycle sample enable
//   crsh          out  4  crash level to the bang generator
//   crsh_trig     out  1  one-cycle pulse when crsh goes 0 -> nonzero
//   overrun       out  1  one-cycle pulse when a pending write is overwritten
//                         before it was applied
//
// Configuration
//   CRSH_DECAY_EN  when defined, crsh steps down by one every DECAY_SAMPLES
//                  sample enables until it reaches 0. When undefined, no decay
//                  counter exists and crsh holds its applied value.
module crash_sound_latch #(
    parameter int unsigned CLK_HZ        = 12_096_000,
    parameter int unsigned SAMPLE_HZ     = 48_000,
    parameter int unsigned DECAY_SAMPLES = 432
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_data,
    output logic       clk_en_48KHz,
    output logic [3:0] crsh,
    output logic       crsh_trig,
    output logic       overrun
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] acc_q,        acc_d;
    logic        tick_q,       tick_d;
    logic        en_q,         en_d;
    logic [4:0]  pending_q,    pending_d;      // {mute, level}
    logic        pend_valid_q, pend_valid_d;
    logic [3:0]  crsh_q,       crsh_d;
    logic        trig_q,       trig_d;
    logic        overrun_q,    overrun_d;

    logic [32:0] acc_sum;
    logic        apply;
    logic [3:0]  apply_level;

`ifdef CRSH_DECAY_EN
    localparam logic [15:0] DECAY_LAST = 16'(DECAY_SAMPLES - 1);
    logic [15:0] decay_cnt_q, decay_cnt_d;
`else
    // Parameter kept for a uniform interface; it has no effect in this build.
    logic [15:0] decay_param_unused;
    assign decay_param_unused = 16'(DECAY_SAMPLES);
`endif

    // Upper data bits carry nothing for this register.
    logic cpu_data_unused;
    assign cpu_data_unused = ^cpu_data[7:5];

    // ------------------------------------------------------------------
    // Fractional rate generator: adds SAMPLE_HZ per clock and wraps at
    // CLK_HZ, so the long-run pulse rate is exact with no drift. The sum is
    // one bit wider so the comparison cannot be fooled by a carry out.
    // tick is registered and then registered again as the enable, which
    // places the first enable after the 253rd edge with the default rates.
    // ------------------------------------------------------------------
    always_comb begin
        acc_sum = {1'b0, acc_q} + 33'(SAMPLE_HZ);
        tick_d  = (acc_sum >= 33'(CLK_HZ));
        if (tick_d) begin
            acc_d = 32'(acc_sum - 33'(CLK_HZ));
        end else begin
            acc_d = acc_sum[31:0];
        end
        en_d = tick_q;
    end

    // ------------------------------------------------------------------
    // Write capture. A write landing on the apply edge replaces the pending
    // slot after the old value has been consumed, so it stays pending and
    // is not an overrun.
    // ------------------------------------------------------------------
    assign apply       = en_q & pend_valid_q;
    assign apply_level = pending_q[4] ? 4'h0 : pending_q[3:0];

    always_comb begin
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = 1'b0;

        if (apply) begin
            pend_valid_d = 1'b0;
        end

        if (cpu_wr) begin
            pending_d    = cpu_data[4:0];
            pend_valid_d = 1'b1;
            overrun_d    = pend_valid_q & ~apply;
        end
    end

    // ------------------------------------------------------------------
    // Output level. Changes only on an enable edge: either an apply or
    // (with decay built) a decay step. Apply wins over decay and restarts
    // the decay interval.
    // ------------------------------------------------------------------
    always_comb begin
        crsh_d = crsh_q;
`ifdef CRSH_DECAY_EN
        decay_cnt_d = decay_cnt_q;
`endif

        if (apply) begin
            crsh_d = apply_level;
`ifdef CRSH_DECAY_EN
            decay_cnt_d = '0;
`endif
        end
`ifdef CRSH_DECAY_EN
        else if (en_q && (crsh_q != 4'h0)) begin
            if (decay_cnt_q == DECAY_LAST) begin
                crsh_d      = crsh_q - 4'h1;
                decay_cnt_d = '0;
            end else begin
                decay_cnt_d = decay_cnt_q + 16'h1;
            end
        end
`endif

        // Registered alongside crsh so the pulse lines up with the new level.
        trig_d = (crsh_q == 4'h0) && (crsh_d != 4'h0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            tick_q       <= 1'b0;
            en_q         <= 1'b0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            crsh_q       <= '0;
            trig_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            tick_q       <= tick_d;
            en_q         <= en_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            crsh_q       <= crsh_d;
            trig_q       <= trig_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef CRSH_DECAY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decay_cnt_q <= '0;
        end else begin
            decay_cnt_q <= decay_cnt_d;
        end
    end
`endif

    assign clk_en_48KHz = en_q;
    assign crsh         = crsh_q;
    assign crsh_trig    = trig_q;
    assign overrun      = overrun_q;

endmodule
